// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the data port.
// Optional read-return watchdog (sticky o_err) is compiled in with ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ireq,
  input  logic [ADDR_W-1:0] i_iaddr,
  output logic [DATA_W-1:0] o_iinst,
  output logic              o_ivalid,
  input  logic              i_dren,
  input  logic              i_dwen,
  input  logic [ADDR_W-1:0] i_daddr,
  input  logic [DATA_W-1:0] i_dwdata,
  output logic [DATA_W-1:0] o_drdata,
  output logic              o_dvalid,
  output logic              o_exstall,
  output logic [ADDR_W-1:0] o_maddr,
  output logic [DATA_W-1:0] o_mwdata,
  output logic              o_mren,
  output logic              o_mwen,
  input  logic [DATA_W-1:0] i_mrdata,
  input  logic              i_mrvd,
  output logic              o_err
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              fetch_q, fetch_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              mren_q, mren_d;
  logic              mwen_q, mwen_d;
  logic [DATA_W-1:0] iinst_q, iinst_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              ivalid_q, ivalid_d;
  logic              dvalid_q, dvalid_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic              any_req_c;
  logic              data_req_c;
  logic              fetch_win_c;
  logic              take_rd_c;
  logic [DATA_W-1:0] rd_word_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  assign data_req_c  = i_dren | i_dwen;
  assign any_req_c   = i_ireq | data_req_c;
  // Fetch wins when data is idle or the data port has used its starvation budget.
  assign fetch_win_c = i_ireq & ((starve_q == STARVE_LIM) | ~data_req_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    store_d   = store_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mren_d    = 1'b0;
    mwen_d    = 1'b0;
    iinst_d   = iinst_q;
    drdata_d  = drdata_q;
    ivalid_d  = 1'b0;
    dvalid_d  = 1'b0;
    starve_d  = starve_q;
    take_rd_c = 1'b0;
    rd_word_c = i_mrdata;
`ifdef ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          state_d = S_ISSUE;
          if (fetch_win_c) begin
            fetch_d  = 1'b1;
            store_d  = 1'b0;
            maddr_d  = i_iaddr;
            mren_d   = 1'b1;
            starve_d = '0;
          end else begin
            // A simultaneous load and store collapses to the store.
            fetch_d  = 1'b0;
            store_d  = i_dwen;
            maddr_d  = i_daddr;
            mwdata_d = i_dwdata;
            mren_d   = ~i_dwen;
            mwen_d   = i_dwen;
            if (i_ireq) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end

      S_ISSUE: begin
        if (store_q) begin
          state_d  = S_RESP;
          dvalid_d = 1'b1;
        end else if (i_mrvd) begin
          state_d   = S_RESP;
          take_rd_c = 1'b1;
        end else begin
          state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end

      S_WAIT: begin
        if (i_mrvd) begin
          state_d   = S_RESP;
          take_rd_c = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_RESP;
          take_rd_c = 1'b1;
          rd_word_c = fetch_q ? NOP_INSN : '0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_rd_c) begin
      if (fetch_q) begin
        iinst_d  = rd_word_c;
        ivalid_d = 1'b1;
      end else begin
        drdata_d = rd_word_c;
        dvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      fetch_q  <= 1'b0;
      store_q  <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mren_q   <= 1'b0;
      mwen_q   <= 1'b0;
      iinst_q  <= '0;
      drdata_q <= '0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      fetch_q  <= fetch_d;
      store_q  <= store_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mren_q   <= mren_d;
      mwen_q   <= mwen_d;
      iinst_q  <= iinst_d;
      drdata_q <= drdata_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      starve_q <= starve_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_exstall = (i_ireq & ~ivalid_q) | (data_req_c & ~dvalid_q);
  assign o_maddr   = maddr_q;
  assign o_mwdata  = mwdata_q;
  assign o_mren    = mren_q;
  assign o_mwen    = mwen_q;
  assign o_iinst   = iinst_q;
  assign o_drdata  = drdata_q;
  assign o_ivalid  = ivalid_q;
  assign o_dvalid  = dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected commands and
// completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ireq;
  logic [31:0] i_iaddr;
  logic [31:0] o_iinst;
  logic        o_ivalid;
  logic        i_dren;
  logic        i_dwen;
  logic [31:0] i_daddr;
  logic [31:0] i_dwdata;
  logic [31:0] o_drdata;
  logic        o_dvalid;
  logic        o_exstall;
  logic [31:0] o_maddr;
  logic [31:0] o_mwdata;
  logic        o_mren;
  logic        o_mwen;
  logic [31:0] i_mrdata;
  logic        i_mrvd;
  logic        o_err;

  mem_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .i_ireq   (i_ireq),
    .i_iaddr  (i_iaddr),
    .o_iinst  (o_iinst),
    .o_ivalid (o_ivalid),
    .i_dren   (i_dren),
    .i_dwen   (i_dwen),
    .i_daddr  (i_daddr),
    .i_dwdata (i_dwdata),
    .o_drdata (o_drdata),
    .o_dvalid (o_dvalid),
    .o_exstall(o_exstall),
    .o_maddr  (o_maddr),
    .o_mwdata (o_mwdata),
    .o_mren   (o_mren),
    .o_mwen   (o_mwen),
    .i_mrdata (i_mrdata),
    .i_mrvd   (i_mrvd),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    int          due;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  exp_t exp_i[$];
  exp_t exp_d[$];
  cmd_t exp_cmd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;   // cycles from o_mren to i_mrvd; >=100 means never
  int stale_cnt = 0;

  logic [31:0] mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen/missed, expected otherwise (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void push_cmd(input bit we, input logic [31:0] a, input logic [31:0] wd);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd;
    exp_cmd.push_back(c);
  endfunction

  // Memory model: read returns, store capture, and stale i_mrvd pulses.
  initial begin
    int served;
    logic [31:0] a;
    served = 0;
    i_mrvd = 1'b0;
    i_mrdata = '0;
    forever begin
      @(negedge clk);
      if (stale_cnt != served) begin
        served++;
        i_mrvd = 1'b1;
        i_mrdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        i_mrvd = 1'b0;
      end else if (o_mren && rst) begin
        a = o_maddr;
        if (mem_lat == 0) begin
          i_mrvd = 1'b1;
          i_mrdata = mem_rd(a);
          @(posedge clk); #1;
          i_mrvd = 1'b0;
        end else if (mem_lat < 100) begin
          repeat (mem_lat) @(posedge clk);
          #1;
          i_mrvd = 1'b1;
          i_mrdata = mem_rd(a);
          @(posedge clk); #1;
          i_mrvd = 1'b0;
        end
      end else if (o_mwen && rst) begin
        mem[o_maddr] = o_mwdata;
      end
    end
  end

  // Monitor: memory commands and completion pulses against the scoreboard.
  initial begin
    cmd_t c;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (o_mren || o_mwen) begin
          if (exp_cmd.size() == 0) fail_evt("cmd_unexpected");
          else begin
            c = exp_cmd.pop_front();
            chk("cmd_mwen", 32'(o_mwen), 32'(c.we));
            chk("cmd_mren", 32'(o_mren), 32'(!c.we));
            chk("cmd_maddr", o_maddr, c.addr);
            if (c.we) chk("cmd_mwdata", o_mwdata, c.wdata);
          end
        end
        if (o_ivalid) begin
          if (exp_i.size() == 0) fail_evt("ivalid_unexpected");
          else begin
            e = exp_i.pop_front();
            if (e.chk_data) chk("iinst", o_iinst, e.data);
            if (e.due >= 0) chk("ivalid_cycle", 32'(cyc), 32'(e.due));
          end
        end
        if (o_dvalid) begin
          if (exp_d.size() == 0) fail_evt("dvalid_unexpected");
          else begin
            e = exp_d.pop_front();
            if (e.chk_data) chk("drdata", o_drdata, e.data);
            if (e.due >= 0) chk("dvalid_cycle", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  task automatic wait_valid(input bit is_fetch, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (is_fetch ? o_ivalid : o_dvalid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Called just after a rising edge; lat < 0 disables the cycle check.
  task automatic req_fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    bit ok;
    e.data = d; e.chk_data = 1'b1; e.due = (lat < 0) ? -1 : cyc + lat;
    exp_i.push_back(e);
    i_ireq = 1'b1;
    i_iaddr = a;
    wait_valid(1'b1, ok);
    if (!ok) fail_evt("fetch_timeout");
    @(posedge clk); #1;
    i_ireq = 1'b0;
  endtask

  task automatic req_data(input bit we, input bit re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] d,
                          input bit chk_data, input int lat);
    exp_t e;
    bit ok;
    e.data = d; e.chk_data = chk_data; e.due = (lat < 0) ? -1 : cyc + lat;
    exp_d.push_back(e);
    i_dwen = we;
    i_dren = re;
    i_daddr = a;
    i_dwdata = wd;
    wait_valid(1'b0, ok);
    if (!ok) fail_evt("data_timeout");
    @(posedge clk); #1;
    i_dren = 1'b0;
    i_dwen = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_ireq = 1'b0; i_iaddr = '0;
    i_dren = 1'b0; i_dwen = 1'b0; i_daddr = '0; i_dwdata = '0;
    mem[32'h40] = 32'h0050_0093;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_maddr", o_maddr, 32'h0);
    chk("rst_mwdata", o_mwdata, 32'h0);
    chk("rst_iinst", o_iinst, 32'h0);
    chk("rst_drdata", o_drdata, 32'h0);
    chk("rst_ctrl", {26'h0, o_mren, o_mwen, o_ivalid, o_dvalid, o_exstall, o_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, memory answers one cycle after o_mren
    mem_lat = 1;
    push_cmd(1'b0, 32'h40, 32'h0);
    begin
      exp_t e;
      e.data = 32'h0050_0093; e.chk_data = 1'b1; e.due = cyc + 3;
      exp_i.push_back(e);
    end
    i_ireq = 1'b1;
    i_iaddr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_exstall_c%0d", k), 32'(o_exstall), (k < 3) ? 32'h1 : 32'h0);
      if (k == 1) chk("t1_mren_c1", 32'(o_mren), 32'h1);
    end
    @(posedge clk); #1;
    i_ireq = 1'b0;

    // Simultaneous fetch and load: load first, fetch in the following IDLE
    push_cmd(1'b0, 32'h100, 32'h0);
    push_cmd(1'b0, 32'h80, 32'h0);
    fork
      req_fetch(32'h80, 32'h5A5A_0080, 7);
      req_data(1'b0, 1'b1, 32'h100, 32'h0, 32'h5A5A_0100, 1'b1, 3);
    join

    // Store, then read it back
    push_cmd(1'b1, 32'h200, 32'hDEAD_BEEF);
    req_data(1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    push_cmd(1'b0, 32'h200, 32'h0);
    req_data(1'b0, 1'b1, 32'h200, 32'h0, 32'hDEAD_BEEF, 1'b1, 3);

    // Zero-latency memory
    mem_lat = 0;
    push_cmd(1'b0, 32'h300, 32'h0);
    req_data(1'b0, 1'b1, 32'h300, 32'h0, 32'h5A5A_0300, 1'b1, 2);

    // Load and store together: store wins
    push_cmd(1'b1, 32'h204, 32'h1234_5678);
    req_data(1'b1, 1'b1, 32'h204, 32'h1234_5678, 32'h0, 1'b0, 2);
    push_cmd(1'b0, 32'h204, 32'h0);
    req_data(1'b0, 1'b1, 32'h204, 32'h0, 32'h1234_5678, 1'b1, 2);

    // Starvation: four data grants, then the waiting fetch, then data resumes
    mem_lat = 1;
    for (int k = 0; k < 4; k++) push_cmd(1'b0, 32'h400 + 32'(4 * k), 32'h0);
    push_cmd(1'b0, 32'h44, 32'h0);
    for (int k = 4; k < 6; k++) push_cmd(1'b0, 32'h400 + 32'(4 * k), 32'h0);
    fork
      req_fetch(32'h44, 32'h5A5A_0044, 19);
      begin
        req_data(1'b0, 1'b1, 32'h400, 32'h0, 32'h5A5A_0400, 1'b1, 3);
        req_data(1'b0, 1'b1, 32'h404, 32'h0, 32'h5A5A_0404, 1'b1, 3);
        req_data(1'b0, 1'b1, 32'h408, 32'h0, 32'h5A5A_0408, 1'b1, 3);
        req_data(1'b0, 1'b1, 32'h40C, 32'h0, 32'h5A5A_040C, 1'b1, 3);
        req_data(1'b0, 1'b1, 32'h410, 32'h0, 32'h5A5A_0410, 1'b1, 7);
        req_data(1'b0, 1'b1, 32'h414, 32'h0, 32'h5A5A_0414, 1'b1, 3);
      end
    join

`ifdef ARB_TIMEOUT_EN
    // Watchdog: no i_mrvd, NOP after 64 WAIT cycles, sticky o_err
    mem_lat = 255;
    push_cmd(1'b0, 32'h50, 32'h0);
    req_fetch(32'h50, 32'h0000_0013, 66);
    chk("tmo_err_set", 32'(o_err), 32'h1);
    mem_lat = 1;
    push_cmd(1'b0, 32'h104, 32'h0);
    req_data(1'b0, 1'b1, 32'h104, 32'h0, 32'h5A5A_0104, 1'b1, 3);
    chk("tmo_err_sticky", 32'(o_err), 32'h1);
`else
    chk("err_tied_low", 32'(o_err), 32'h0);
`endif

    // Reset in WAIT, then a stale i_mrvd, then a normal fetch
    mem_lat = 255;
    push_cmd(1'b0, 32'h48, 32'h0);
    i_ireq = 1'b1;
    i_iaddr = 32'h48;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    i_ireq = 1'b0;
    @(negedge clk);
    chk("mrst_maddr", o_maddr, 32'h0);
    chk("mrst_iinst", o_iinst, 32'h0);
    chk("mrst_drdata", o_drdata, 32'h0);
    chk("mrst_ctrl", {27'h0, o_mren, o_mwen, o_ivalid, o_dvalid, o_err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    stale_cnt = stale_cnt + 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mrst_quiet", {29'h0, o_ivalid, o_dvalid, o_mren}, 32'h0);
    end
    @(posedge clk); #1;
    mem_lat = 1;
    push_cmd(1'b0, 32'h4C, 32'h0);
    req_fetch(32'h4C, 32'h5A5A_004C, 3);

    repeat (4) @(posedge clk);
    chk("end_exp_i_empty", 32'(exp_i.size()), 32'h0);
    chk("end_exp_d_empty", 32'(exp_d.size()), 32'h0);
    chk("end_exp_cmd_empty", 32'(exp_cmd.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and its data load/store port. Sequences each access over a valid-handshake memory interface and returns fetched words and load data. Drives the core's external stall input while any request is outstanding. Sits between the core and the memory model in the SoC top and the testbench.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants allowed while a fetch waits; range 1..15
TIMEOUT, 64, cycles to wait for i_mrvd; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_ireq  in  1  fetch request; held until o_ivalid
i_iaddr  in  ADDR_W  fetch address; stable while i_ireq
o_iinst  out  DATA_W  fetched word; registered, held until next fetch completes
o_ivalid  out  1  one-cycle fetch completion pulse
i_dren  in  1  load request; held until o_dvalid
i_dwen  in  1  store request; held until o_dvalid
i_daddr  in  ADDR_W  data address
i_dwdata  in  DATA_W  store data
o_drdata  out  DATA_W  load data; registered, held
o_dvalid  out  1  one-cycle load/store completion pulse
o_exstall  out  1  core stall, combinational
o_maddr  out  ADDR_W  memory address, registered
o_mwdata  out  DATA_W  memory write data, registered
o_mren  out  1  memory read command, one-cycle pulse
o_mwen  out  1  memory write command, one-cycle pulse
i_mrdata  in  DATA_W  memory read data, valid with i_mrvd
i_mrvd  in  1  memory read data valid
o_err  out  1  sticky timeout flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst=0, async): state IDLE; all registered outputs 0; starve counter 0; o_err 0.
- FSM states and transitions:
  - IDLE: arbitrate among pending requests and latch the winner, address and write data, then go to ISSUE. With no request, stay in IDLE.
  - ISSUE: assert o_mren or o_mwen for exactly one cycle. For a store, go to RESP. For a read, go to RESP if i_mrvd is high this cycle (zero-latency memory), otherwise go to WAIT.
  - WAIT: on i_mrvd, capture i_mrdata into o_iinst or o_drdata and go to RESP. Otherwise stay in WAIT.
  - RESP: pulse o_ivalid or o_dvalid for one cycle and ignore all requests. Return to IDLE.
  - A requester must drop its request, or present a new request, in the cycle after its valid pulse.
- Latency from request, counting from cycle 0:
  - Store: o_mwen in cycle 1, o_dvalid in cycle 2.
  - Read with i_mrvd in cycle 2: o_*valid in cycle 3.
  - Back-to-back accesses therefore cost 4 cycles per read.
- Arbitration:
  - Data has priority over fetch.
  - The starve counter increments on each data grant made while i_ireq=1. It saturates at STARVE_MAX.
  - When the counter equals STARVE_MAX and i_ireq=1, the fetch is granted and the counter clears.
  - Any fetch grant clears the counter.
- If i_dren and i_dwen are both high, the store wins and the load is dropped.
- i_mrvd is ignored in IDLE, ISSUE-store, and RESP, which covers stale returns after reset.
- o_exstall = (i_ireq & ~o_ivalid) | ((i_dren|i_dwen) & ~o_dvalid).
- The memory address is passed through unmodified; the full ADDR_W goes to the memory, which decodes byte/word.
- Reset mid-operation forces IDLE immediately. Any partial access is abandoned and no valid pulse is generated.

Optional Feature:
Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - After TIMEOUT cycles without i_mrvd, go to RESP with a substituted result: o_iinst=32'h0000_0013 (NOP) for a fetch, o_drdata=0 for a load.
  - Set o_err. o_err clears only on reset.
- Undefined: WAIT holds indefinitely; o_err is tied to 0; no counter logic is present.

Test Plan:
- Fetch only: i_ireq=1, i_iaddr=0x40; memory returns 0x00500093 one cycle after o_mren -> o_maddr=0x40, o_mren in cycle 1, o_ivalid and o_iinst=0x00500093 in cycle 3, o_exstall=1 in cycles 0-2 and 0 in cycle 3.
- Simultaneous fetch and load at 0x100 -> load served first (o_maddr=0x100), o_dvalid before the fetch is issued; fetch issued in the following IDLE.
- Store: i_dwen=1, i_daddr=0x200, i_dwdata=0xDEADBEEF -> o_mwen one cycle with o_maddr=0x200 and o_mwdata=0xDEADBEEF; o_dvalid 2 cycles after request; o_mren never asserted.
- Starvation: i_ireq held while back-to-back loads are requested, STARVE_MAX=4 -> exactly 4 data grants, then the fetch is granted, then data resumes.
- Reset mid-WAIT: drop rst during WAIT, release, then pulse i_mrvd -> no o_*valid, state IDLE, outputs 0; the next request completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT=64, fetch with no i_mrvd -> o_ivalid with o_iinst=0x00000013 after 64 WAIT cycles; o_err=1 and stays 1 until reset.
